vga_frame_fetch_ctrl: RTL

- Read scheduler for the VGA display path: keeps the pixel FIFO between SDRAM and the VGA colour-output stage topped up.
- Issues burst read requests to the SDRAM controller for one RGB565 frame.
- Address and length are generated per burst.
- Resynchronises to each frame start, restarting at the frame base address and flushing stale FIFO contents.
- Sits between the VGA timing generator, the display FIFO and the SDRAM read port.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_frame_fetch_ctrl_if.sv | 13 +
 rtl/vga_frame_fetch_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: display-path constants shared by the frame fetcher and the colour-output stage
package vga_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_REQ   = 3'd3;
  localparam logic [2:0] ST_BUSY  = 3'd4;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;
endpackage

// File: rtl/vga_frame_fetch_ctrl_if.sv
// vga_frame_fetch_ctrl_if: burst read request port between the frame fetcher and the SDRAM controller
interface vga_frame_fetch_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 9
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_done;
  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/vga_frame_fetch_ctrl.sv
// vga_frame_fetch_ctrl: keeps the display FIFO topped up with one-at-a-time SDRAM bursts, resyncing on each frame start
module vga_frame_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = FRAME_PIXELS,
  parameter int BURST_LEN   = 256,
  parameter int FIFO_DEPTH  = 1024,
  parameter int LVL_W       = 11,
  parameter int LEN_W       = 9
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   frame_start,
  input  logic [LVL_W-1:0]       fifo_level,
  output logic                   fifo_clr,
  output logic                   frame_active,
  output logic                   overrun_err,
  vga_frame_fetch_ctrl_if.master rd
);
  localparam int WL_W = $clog2(FRAME_WORDS + 1);
  localparam logic [LVL_W-1:0] THRESH = LVL_W'(FIFO_DEPTH - BURST_LEN);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WL_W-1:0]   words_q, words_d;
  logic              pend_q, pend_d, active_q, active_d, ovr_q, ovr_d;
  assign rd.rd_req    = state_q == ST_REQ;
  assign rd.rd_addr   = addr_q;
  assign rd.rd_len    = len_q;
  assign fifo_clr     = state_q == ST_FLUSH;
  assign frame_active = active_q;
  assign overrun_err  = ovr_q;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    words_d  = words_q;
    pend_d   = pend_q;
    active_d = active_q;
    ovr_d    = ovr_q | (frame_start && state_q != ST_IDLE && words_q != '0);
    case (state_q)
      ST_IDLE: state_d = frame_start ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: begin
        addr_d  = ADDR_W'(BASE_ADDR);
        words_d = WL_W'(FRAME_WORDS);
        state_d = ST_WAIT;
      end
      ST_WAIT:
        if (frame_start) state_d = ST_FLUSH;
        else if (words_q == '0) active_d = 1'b0;
        else if (fifo_level <= THRESH) begin
          len_d    = (32'(words_q) < 32'(BURST_LEN)) ? LEN_W'(words_q) : LEN_W'(BURST_LEN);
          active_d = 1'b1;
          state_d  = ST_REQ;
        end
      ST_REQ: begin
        pend_d  = pend_q | frame_start;
        state_d = rd.rd_ack ? ST_BUSY : ST_REQ;
      end
      ST_BUSY: begin
        pend_d = pend_q | frame_start;
        if (rd.rd_done) begin
          addr_d  = addr_q + ADDR_W'(len_q);
          words_d = words_q - WL_W'(len_q);
          pend_d  = 1'b0;
          state_d = (pend_q || frame_start) ? ST_FLUSH : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      addr_q   <= ADDR_W'(BASE_ADDR);
      len_q    <= '0;
      words_q  <= '0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      words_q  <= words_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      ovr_q    <= ovr_d;
    end
  end
endmodule
